// File: rtl/lane_dispatch.sv
// lane_dispatch
//   Issue-side driver for the SIMD lanes. Accepts one decoded instruction via
//   instr_valid/instr_ready, then issues it to the lane array as a sequence of
//   beats, one per thread group. There are ceil(total_threads/NUM_THREADS)
//   beats. Every output is registered.
//
//   Optional feature: define LANE_DISPATCH_PERF_EN to add the perf_beats and
//   perf_stalls saturating counters.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   instr_valid/instr_ready  decode handshake (ready only in IDLE)
//   in_funct4, in_imm, in_ad1..3, in_is_int, in_is_float, in_we3
//                            instruction fields, latched on accept
//   total_threads            threads in launch, sampled on accept
//   stall                    lane stall: hold the current beat
//   issue_valid, threads, bIdx
//                            beat valid, active-thread mask, beat index
//   FUNCT4, IMM, AD1..3, is_int, is_float, WE3
//                            latched (sanitised) instruction fields
//   done                     one-cycle pulse when a launch completes
//   perf_beats, perf_stalls  (LANE_DISPATCH_PERF_EN only) event counters
//
// State  | meaning
// IDLE   | instr_ready=1; waiting for an instruction
// ISSUE  | driving beats; advance on each cycle without stall
module lane_dispatch #(
    parameter int NUM_THREADS = 4,
    parameter int BIDX_W      = 32,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [3:0]             in_funct4,
    input  logic [31:0]            in_imm,
    input  logic [4:0]             in_ad1,
    input  logic [4:0]             in_ad2,
    input  logic [4:0]             in_ad3,
    input  logic                   in_is_int,
    input  logic                   in_is_float,
    input  logic                   in_we3,
    input  logic [CNT_W-1:0]       total_threads,
    input  logic                   stall,
    output logic                   issue_valid,
    output logic [NUM_THREADS-1:0] threads,
    output logic [BIDX_W-1:0]      bIdx,
    output logic [3:0]             FUNCT4,
    output logic [31:0]            IMM,
    output logic [4:0]             AD1,
    output logic [4:0]             AD2,
    output logic [4:0]             AD3,
    output logic                   is_int,
    output logic                   is_float,
    output logic                   WE3,
    output logic                   done
`ifdef LANE_DISPATCH_PERF_EN
    ,
    output logic [31:0]            perf_beats,
    output logic [31:0]            perf_stalls
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] NT = CNT_W'(NUM_THREADS);

    state_t                 state_q, state_d;
    logic                   iv_q, iv_d;
    logic [NUM_THREADS-1:0] thr_q, thr_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [CNT_W-1:0]       last_q, last_d;
    logic [NUM_THREADS-1:0] fmask_q, fmask_d;
    logic [3:0]             funct4_q, funct4_d;
    logic [31:0]            imm_q, imm_d;
    logic [4:0]             ad1_q, ad1_d;
    logic [4:0]             ad2_q, ad2_d;
    logic [4:0]             ad3_q, ad3_d;
    logic                   is_int_q, is_int_d;
    logic                   is_float_q, is_float_d;
    logic                   we3_q, we3_d;
    logic                   done_q, done_d;

    // Launch geometry from the incoming total: index of the final beat and
    // the mask for that beat (a zero remainder means a full final group).
    logic [CNT_W-1:0]       last_in;
    logic [CNT_W-1:0]       rem_in;
    logic [NUM_THREADS-1:0] fmask_in;
    logic [CNT_W-1:0]       beat_nxt;

    always_comb begin
        last_in  = (total_threads - CNT_W'(1)) / NT;
        rem_in   = total_threads % NT;
        fmask_in = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            fmask_in[i] = (rem_in == '0) || (CNT_W'(i) < rem_in);
        end
    end

    always_comb begin
        state_d    = state_q;
        iv_d       = iv_q;
        thr_d      = thr_q;
        beat_d     = beat_q;
        last_d     = last_q;
        fmask_d    = fmask_q;
        funct4_d   = funct4_q;
        imm_d      = imm_q;
        ad1_d      = ad1_q;
        ad2_d      = ad2_q;
        ad3_d      = ad3_q;
        is_int_d   = is_int_q;
        is_float_d = is_float_q;
        we3_d      = we3_q;
        done_d     = 1'b0;
        beat_nxt   = beat_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    funct4_d   = in_funct4;
                    imm_d      = in_imm;
                    ad1_d      = in_ad1;
                    ad2_d      = in_ad2;
                    ad3_d      = in_ad3;
                    // Int wins over float; an untyped op must never write
                    // back, since the lane result would be garbage.
                    is_int_d   = in_is_int;
                    is_float_d = in_is_float & ~in_is_int;
                    we3_d      = in_we3 & (in_is_int | in_is_float);
                    last_d     = last_in;
                    fmask_d    = fmask_in;
                    beat_d     = '0;
                    if (total_threads == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        iv_d    = 1'b1;
                        thr_d   = (last_in == '0) ? fmask_in : '1;
                    end
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (beat_q == last_q) begin
                        state_d = IDLE;
                        iv_d    = 1'b0;
                        thr_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_nxt;
                        thr_d  = (beat_nxt == last_q) ? fmask_q : '1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                iv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            iv_q       <= 1'b0;
            thr_q      <= '0;
            beat_q     <= '0;
            last_q     <= '0;
            fmask_q    <= '0;
            funct4_q   <= '0;
            imm_q      <= '0;
            ad1_q      <= '0;
            ad2_q      <= '0;
            ad3_q      <= '0;
            is_int_q   <= 1'b0;
            is_float_q <= 1'b0;
            we3_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iv_q       <= iv_d;
            thr_q      <= thr_d;
            beat_q     <= beat_d;
            last_q     <= last_d;
            fmask_q    <= fmask_d;
            funct4_q   <= funct4_d;
            imm_q      <= imm_d;
            ad1_q      <= ad1_d;
            ad2_q      <= ad2_d;
            ad3_q      <= ad3_d;
            is_int_q   <= is_int_d;
            is_float_q <= is_float_d;
            we3_q      <= we3_d;
            done_q     <= done_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign issue_valid = iv_q;
    assign threads     = thr_q;
    assign bIdx        = BIDX_W'(beat_q);
    assign FUNCT4      = funct4_q;
    assign IMM         = imm_q;
    assign AD1         = ad1_q;
    assign AD2         = ad2_q;
    assign AD3         = ad3_q;
    assign is_int      = is_int_q;
    assign is_float    = is_float_q;
    assign WE3         = we3_q;
    assign done        = done_q;

`ifdef LANE_DISPATCH_PERF_EN
    logic [31:0] perf_beats_q, perf_beats_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_beats_d  = perf_beats_q;
        perf_stalls_d = perf_stalls_q;
        if (iv_q && !stall && (perf_beats_q != '1)) begin
            perf_beats_d = perf_beats_q + 32'd1;
        end
        if (iv_q && stall && (perf_stalls_q != '1)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_beats_q  <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_beats_q  <= perf_beats_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_beats  = perf_beats_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
